// File: rtl/data_mem_arbiter_if.sv
// rtl/data_mem_arbiter_if.sv - CPU, host and RAM signal bundle for the data memory arbiter
interface data_mem_arbiter_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
) ();
    // CPU memory stage
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_stall;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_rvalid;

    // host / loader port
    logic              host_req;
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic              host_gnt;
    logic [DATA_W-1:0] host_rdata;
    logic              host_rvalid;

    // RAM side
    logic [ADDR_W-1:0] ram_rdaddress;
    logic [ADDR_W-1:0] ram_wraddress;
    logic [DATA_W-1:0] ram_data;
    logic              ram_wren;
    logic [DATA_W-1:0] ram_q;

    // arbiter side
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_stall, cpu_rdata, cpu_rvalid,
        input  host_req, host_we, host_addr, host_wdata,
        output host_gnt, host_rdata, host_rvalid,
        output ram_rdaddress, ram_wraddress, ram_data, ram_wren,
        input  ram_q
    );

    // requesters plus RAM model side
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_stall, cpu_rdata, cpu_rvalid,
        output host_req, host_we, host_addr, host_wdata,
        input  host_gnt, host_rdata, host_rvalid,
        input  ram_rdaddress, ram_wraddress, ram_data, ram_wren,
        output ram_q
    );
endinterface

// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - CPU/host data RAM arbiter with forced host grant; optional stats via DATA_MEM_ARB_STATS_EN
module data_mem_arbiter #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 16,
    parameter int MAX_WAIT = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    data_mem_arbiter_if.slave  bus,
    output logic [15:0]        stall_count,
    output logic [15:0]        conflict_count
);

    typedef enum logic {
        S_NORM,
        S_FORCE
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_CPU,
        OWN_HOST
    } owner_t;

    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    state_t            state;
    state_t            state_next;
    logic [3:0]        wait_cnt;
    logic [3:0]        wait_next;

    logic              host_win;
    logic              cpu_win;
    logic              granted;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic [ADDR_W-1:0] last_addr;
    logic [DATA_W-1:0] last_data;

    owner_t            rd_owner;
    owner_t            rd_owner_next;
    logic [DATA_W-1:0] cpu_hold;
    logic [DATA_W-1:0] host_hold;
    logic              stall_now;

    // Grant decision: the host wins when the CPU is idle or the host is owed a forced beat
    always_comb begin
        host_win = 1'b0;
        cpu_win  = 1'b0;
        if (rst_n) begin
            if (bus.host_req && (state == S_FORCE || !bus.cpu_req)) begin
                host_win = 1'b1;
            end else if (bus.cpu_req) begin
                cpu_win = 1'b1;
            end
        end
    end

    // Next state: count consecutive host losses and schedule one forced host beat at the limit
    always_comb begin
        state_next = S_NORM;
        wait_next  = wait_cnt;
        if (!bus.host_req || host_win) begin
            wait_next = 4'd0;
        end else begin
            wait_next = wait_cnt + 4'd1;
        end
        if (state == S_NORM && bus.host_req && !host_win && wait_next == MAX_WAIT_C) begin
            state_next = S_FORCE;
        end
    end

    // State and host-loss counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_NORM;
            wait_cnt <= 4'd0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_next;
        end
    end

    // RAM mux: follow the granted requester, otherwise hold the last driven address/data
    always_comb begin
        granted  = host_win | cpu_win;
        sel_we   = 1'b0;
        sel_addr = last_addr;
        sel_data = last_data;
        if (host_win) begin
            sel_we   = bus.host_we;
            sel_addr = bus.host_addr;
            sel_data = bus.host_wdata;
        end else if (cpu_win) begin
            sel_we   = bus.cpu_we;
            sel_addr = bus.cpu_addr;
            sel_data = bus.cpu_wdata;
        end
    end

    // Remember the last granted address/data so an idle cycle does not disturb the RAM inputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_addr <= '0;
            last_data <= '0;
        end else if (granted) begin
            last_addr <= sel_addr;
            last_data <= sel_data;
        end
    end

    assign bus.ram_rdaddress = rst_n ? sel_addr : '0;
    assign bus.ram_wraddress = rst_n ? sel_addr : '0;
    assign bus.ram_data      = rst_n ? sel_data : '0;
    assign bus.ram_wren      = granted & sel_we;
    assign bus.host_gnt      = host_win;
    assign stall_now         = rst_n & bus.cpu_req & ~cpu_win;
    assign bus.cpu_stall     = stall_now;

    // Tag the owner of a granted read so the next cycle's ram_q goes back to it
    always_comb begin
        rd_owner_next = OWN_NONE;
        if (host_win && !bus.host_we) begin
            rd_owner_next = OWN_HOST;
        end else if (cpu_win && !bus.cpu_we) begin
            rd_owner_next = OWN_CPU;
        end
    end

    // Read-return tag plus per-port hold registers so the non-owner keeps its last data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_owner  <= OWN_NONE;
            cpu_hold  <= '0;
            host_hold <= '0;
        end else begin
            rd_owner <= rd_owner_next;
            if (rd_owner == OWN_CPU) begin
                cpu_hold <= bus.ram_q;
            end
            if (rd_owner == OWN_HOST) begin
                host_hold <= bus.ram_q;
            end
        end
    end

    assign bus.cpu_rvalid  = (rd_owner == OWN_CPU);
    assign bus.host_rvalid = (rd_owner == OWN_HOST);
    assign bus.cpu_rdata   = (rd_owner == OWN_CPU)  ? bus.ram_q : cpu_hold;
    assign bus.host_rdata  = (rd_owner == OWN_HOST) ? bus.ram_q : host_hold;

`ifdef DATA_MEM_ARB_STATS_EN
    // Saturating counters of CPU stall cycles and contested cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count    <= 16'd0;
            conflict_count <= 16'd0;
        end else begin
            if (stall_now && stall_count != 16'hFFFF) begin
                stall_count <= stall_count + 16'd1;
            end
            if (bus.cpu_req && bus.host_req && conflict_count != 16'hFFFF) begin
                conflict_count <= conflict_count + 16'd1;
            end
        end
    end
`else
    assign stall_count    = 16'd0;
    assign conflict_count = 16'd0;
`endif

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb/tb_data_mem_arbiter.sv - randomized and directed checks of data_mem_arbiter against a behavioural model
module tb_data_mem_arbiter;

    localparam int MAX_WAIT = 4;

    logic        clk;
    logic        rst_n;
    logic [15:0] stall_count;
    logic [15:0] conflict_count;

    data_mem_arbiter_if #(.DATA_W(16), .ADDR_W(16)) bus ();

    data_mem_arbiter #(
        .DATA_W   (16),
        .ADDR_W   (16),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus),
        .stall_count    (stall_count),
        .conflict_count (conflict_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM with registered read output
    logic [15:0] ram [0:255];
    always @(posedge clk) begin
        if (bus.ram_wren) ram[bus.ram_wraddress[7:0]] <= bus.ram_data;
        bus.ram_q <= ram[bus.ram_rdaddress[7:0]];
    end

    int total = 0;
    int bad   = 0;

    // behavioural model state
    logic [15:0] shadow [0:255];
    int          m_losses;
    bit          m_force;
    int          m_pend;          // 0 none, 1 cpu, 2 host
    logic [15:0] m_pend_data;
    logic [15:0] m_cpu_hold;
    logic [15:0] m_host_hold;
    logic [15:0] m_last_addr;
    logic [15:0] m_last_data;
    int          m_stalls;
    int          m_conflicts;

    // values observed during the last step
    logic        obs_hgnt, obs_stall, obs_wren, obs_cv, obs_hv;
    logic [15:0] obs_wraddr, obs_data, obs_cd, obs_hd, obs_sc, obs_cc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_losses    = 0;
        m_force     = 0;
        m_pend      = 0;
        m_pend_data = '0;
        m_cpu_hold  = '0;
        m_host_hold = '0;
        m_last_addr = '0;
        m_last_data = '0;
        m_stalls    = 0;
        m_conflicts = 0;
    endtask

    function automatic logic [15:0] sat16(input int v);
        return (v > 65535) ? 16'hFFFF : 16'(v);
    endfunction

    // one clock cycle: check every output against the model, advance the model, cross the edge
    task automatic step();
        bit          hg, cg, st, ew;
        logic [15:0] ea, ed, exp_cd, exp_hd, exp_sc, exp_cc;
        #1;
        hg = bus.host_req && (m_force || !bus.cpu_req);
        cg = bus.cpu_req && !hg;
        st = bus.cpu_req && !cg;
        ea = hg ? bus.host_addr  : (cg ? bus.cpu_addr  : m_last_addr);
        ed = hg ? bus.host_wdata : (cg ? bus.cpu_wdata : m_last_data);
        ew = hg ? bus.host_we    : (cg ? bus.cpu_we    : 1'b0);
        exp_cd = (m_pend == 1) ? m_pend_data : m_cpu_hold;
        exp_hd = (m_pend == 2) ? m_pend_data : m_host_hold;
`ifdef DATA_MEM_ARB_STATS_EN
        exp_sc = sat16(m_stalls);
        exp_cc = sat16(m_conflicts);
`else
        exp_sc = 16'd0;
        exp_cc = 16'd0;
`endif
        chk("host_gnt",      bus.host_gnt,      hg);
        chk("cpu_stall",     bus.cpu_stall,     st);
        chk("ram_rdaddress", bus.ram_rdaddress, ea);
        chk("ram_wraddress", bus.ram_wraddress, ea);
        chk("ram_data",      bus.ram_data,      ed);
        chk("ram_wren",      bus.ram_wren,      ew);
        chk("cpu_rvalid",    bus.cpu_rvalid,    m_pend == 1);
        chk("host_rvalid",   bus.host_rvalid,   m_pend == 2);
        chk("cpu_rdata",     bus.cpu_rdata,     exp_cd);
        chk("host_rdata",    bus.host_rdata,    exp_hd);
        chk("stall_count",   stall_count,       exp_sc);
        chk("conflict_count", conflict_count,   exp_cc);

        obs_hgnt = bus.host_gnt;   obs_stall = bus.cpu_stall; obs_wren = bus.ram_wren;
        obs_wraddr = bus.ram_wraddress; obs_data = bus.ram_data;
        obs_cv = bus.cpu_rvalid;   obs_hv = bus.host_rvalid;
        obs_cd = bus.cpu_rdata;    obs_hd = bus.host_rdata;
        obs_sc = stall_count;      obs_cc = conflict_count;

        m_cpu_hold  = exp_cd;
        m_host_hold = exp_hd;
        m_pend = 0;
        if (hg && !bus.host_we) begin
            m_pend = 2; m_pend_data = shadow[bus.host_addr[7:0]];
        end else if (cg && !bus.cpu_we) begin
            m_pend = 1; m_pend_data = shadow[bus.cpu_addr[7:0]];
        end
        if (hg && bus.host_we) shadow[bus.host_addr[7:0]] = bus.host_wdata;
        if (cg && bus.cpu_we)  shadow[bus.cpu_addr[7:0]]  = bus.cpu_wdata;
        if (hg || cg) begin
            m_last_addr = ea; m_last_data = ed;
        end
        if (st) m_stalls++;
        if (bus.cpu_req && bus.host_req) m_conflicts++;
        // host is owed a win after losing MAX_WAIT contested cycles in a row
        if (hg || !bus.host_req) m_losses = 0;
        else m_losses++;
        m_force = (m_losses == MAX_WAIT) && bus.host_req;
        @(posedge clk);
        #1;
    endtask

    task automatic set_cpu(input bit req, input bit we, input logic [15:0] a, input logic [15:0] d);
        bus.cpu_req = req; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d;
    endtask

    task automatic set_host(input bit req, input bit we, input logic [15:0] a, input logic [15:0] d);
        bus.host_req = req; bus.host_we = we; bus.host_addr = a; bus.host_wdata = d;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram[i]    = 16'($urandom);
            shadow[i] = ram[i];
        end
        rst_n = 1'b0;
        set_cpu(1, 1, 16'h0005, 16'hABCD);
        set_host(1, 1, 16'h0007, 16'h1234);
        repeat (3) @(posedge clk);
        #1;
        // outputs forced quiet while reset is held, even with both requesting
        chk("rst_wren",   bus.ram_wren,      1'b0);
        chk("rst_gnt",    bus.host_gnt,      1'b0);
        chk("rst_stall",  bus.cpu_stall,     1'b0);
        chk("rst_rdaddr", bus.ram_rdaddress, 16'h0000);
        chk("rst_wraddr", bus.ram_wraddress, 16'h0000);
        chk("rst_data",   bus.ram_data,      16'h0000);
        chk("rst_cv",     bus.cpu_rvalid,    1'b0);
        chk("rst_hv",     bus.host_rvalid,   1'b0);
        chk("rst_cd",     bus.cpu_rdata,     16'h0000);
        chk("rst_hd",     bus.host_rdata,    16'h0000);
        chk("rst_sc",     stall_count,       16'h0000);
        chk("rst_cc",     conflict_count,    16'h0000);

        rst_n = 1'b1;
        model_reset();

        // CPU-only store
        set_host(0, 0, 16'h0000, 16'h0000);
        set_cpu(1, 1, 16'h000E, 16'h0DB2);
        step();
        chk("store_wren",  obs_wren,   1'b1);
        chk("store_addr",  obs_wraddr, 16'h000E);
        chk("store_data",  obs_data,   16'h0DB2);
        chk("store_stall", obs_stall,  1'b0);
        chk("store_gnt",   obs_hgnt,   1'b0);

        // CPU read back of the store
        set_cpu(1, 0, 16'h000E, 16'h0000);
        step();
        chk("store_no_rvalid", obs_cv, 1'b0);
        set_cpu(0, 0, 16'h0000, 16'h0000);
        step();
        chk("rd_cv", obs_cv, 1'b1);
        chk("rd_cd", obs_cd, 16'h0DB2);
        chk("rd_hv", obs_hv, 1'b0);

        // alternating owners: host then CPU on consecutive cycles
        set_host(1, 1, 16'h0010, 16'h1111); step();
        set_host(1, 1, 16'h0011, 16'h2222); step();
        set_host(1, 0, 16'h0010, 16'h0000); step();
        set_host(0, 0, 16'h0000, 16'h0000);
        set_cpu(1, 0, 16'h0011, 16'h0000);  step();
        chk("alt_hv1", obs_hv, 1'b1);
        chk("alt_hd1", obs_hd, 16'h1111);
        chk("alt_cv1", obs_cv, 1'b0);
        set_cpu(0, 0, 16'h0000, 16'h0000);  step();
        chk("alt_cv2", obs_cv, 1'b1);
        chk("alt_cd2", obs_cd, 16'h2222);
        chk("alt_hv2", obs_hv, 1'b0);
        chk("alt_hd2", obs_hd, 16'h1111);

        // sustained contention: host loses MAX_WAIT beats, wins one, CPU resumes
        set_cpu(1, 0, 16'h0030, 16'h0000);
        set_host(1, 0, 16'h0020, 16'h0000);
        for (int c = 1; c <= 6; c++) begin
            step();
            chk($sformatf("cont_gnt%0d", c),   obs_hgnt,  c == 5);
            chk($sformatf("cont_stall%0d", c), obs_stall, c == 5);
        end
        set_cpu(0, 0, 16'h0000, 16'h0000);
        set_host(0, 0, 16'h0000, 16'h0000);
        step();
`ifdef DATA_MEM_ARB_STATS_EN
        chk("stats_conflict", obs_cc, 16'd6);
        chk("stats_stall",    obs_sc, 16'd1);
`else
        chk("stats_conflict", obs_cc, 16'd0);
        chk("stats_stall",    obs_sc, 16'd0);
`endif

        // reset while a CPU read is returning
        set_cpu(1, 0, 16'h000E, 16'h0000);
        step();
        set_cpu(0, 0, 16'h0000, 16'h0000);
        chk("mid_cv_before", bus.cpu_rvalid, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_cv_reset", bus.cpu_rvalid, 1'b0);
        chk("mid_cd_reset", bus.cpu_rdata,  16'h0000);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        repeat (3) begin
            step();
            chk("post_rst_cv", obs_cv, 1'b0);
            chk("post_rst_cd", obs_cd, 16'h0000);
        end

        // randomized traffic; host holds its request until granted, CPU holds while stalled
        for (int n = 0; n < 600; n++) begin
            if (!bus.host_req && $urandom_range(0, 2) == 0)
                set_host(1, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 31)), 16'($urandom));
            if (!obs_stall)
                set_cpu($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                        16'($urandom_range(0, 31)), 16'($urandom));
            step();
            if (obs_hgnt) bus.host_req = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Shares the single-port-per-cycle data RAM between two requesters: the CPU memory stage and a host/loader port used for image and data preload and readback.
- Sits between the ExecuteMemory pipeline outputs (address after memory decode, write data, write enable) and the RAM instance.
- Arbitrates every cycle and returns one-cycle-latency read data to the requester that issued the read.
- Stalls the CPU whenever the host is granted over a pending CPU request.

Parameters:
- DATA_W, 16: data width of the RAM and both ports.
- ADDR_W, 16: address width driven to the RAM.
- MAX_WAIT, 4: contested cycles the host may lose in a row before it is forced a grant; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- cpu_req  in  1  CPU memory-stage access request this cycle.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  decoded RAM address.
- cpu_wdata  in  DATA_W  store data.
- cpu_stall  out  1  CPU request not serviced this cycle; pipeline must hold.
- cpu_rdata  out  DATA_W  read data.
- cpu_rvalid  out  1  cpu_rdata valid, one cycle after the granted read.
- host_req  in  1  host access request; held until host_gnt.
- host_we  in  1  1 = write, 0 = read.
- host_addr  in  ADDR_W  host address.
- host_wdata  in  DATA_W  host write data.
- host_gnt  out  1  host access accepted this cycle.
- host_rdata  out  DATA_W  read data.
- host_rvalid  out  1  host_rdata valid, one cycle after the granted read.
- ram_rdaddress  out  ADDR_W  RAM read address.
- ram_wraddress  out  ADDR_W  RAM write address; always equal to ram_rdaddress.
- ram_data  out  DATA_W  RAM write data.
- ram_wren  out  1  RAM write enable.
- ram_q  in  DATA_W  RAM registered read output; valid the cycle after the address.

Behaviour:
- Grant decision is combinational from the requests and registered state. All grants are single-cycle beats.

Grant rules (state S_NORM):
- Only cpu_req: CPU granted.
- Only host_req: host granted.
- Both: CPU granted, host_gnt = 0, wait_cnt increments.
- Neither: no grant, ram_wren = 0, address holds its last value.

Forced host grant:
- When wait_cnt == MAX_WAIT and host_req is high, the FSM enters S_FORCE.
- In S_FORCE the host is granted regardless of cpu_req, and cpu_stall = cpu_req.
- S_FORCE lasts exactly one cycle, then returns to S_NORM.
- wait_cnt clears on any host grant, and whenever host_req is low.

Datapath:
- RAM muxes (ram_rdaddress, ram_wraddress, ram_data) follow the granted requester.
- ram_wren = granted & granted_we.
- cpu_stall = cpu_req & ~cpu_granted. It is never asserted for a CPU that is not requesting.

Read return:
- Registered tag rd_owner (NONE/CPU/HOST) is set on a granted read.
- Next cycle, ram_q is routed to the owner's rdata and the owner's rvalid pulses for one cycle.
- The non-owner's rdata holds its previous value.

Boundary conditions:
- Back-to-back reads by alternating owners are supported; the tag advances every cycle.
- Writes produce no rvalid.
- No read-after-write forwarding; same-address ordering follows grant order.

Reset:
- Asserting rst_n low at any time, including with a read in flight, immediately forces: state S_NORM, wait_cnt 0, rd_owner NONE, cpu_rvalid 0, host_rvalid 0, cpu_rdata 0, host_rdata 0.
- The in-flight read is dropped; no rvalid pulses after reset release.
- Combinational outputs during reset: ram_wren 0, host_gnt 0, cpu_stall 0, addresses and ram_data 0.

Optional Feature:
- Macro: DATA_MEM_ARB_STATS_EN.
- Defined: adds outputs stall_count[15:0] and conflict_count[15:0], both registered.
- stall_count increments on each cycle with cpu_stall = 1; conflict_count increments on each cycle with cpu_req & host_req.
- Both counters saturate at 16'hFFFF and reset to 0.
- Not defined: both ports still exist and are tied to 0, with no counter logic.

Test Plan:
- CPU-only store: cpu_req=1, cpu_we=1, cpu_addr=16'h000E, cpu_wdata=16'h0DB2 -> same cycle ram_wren=1, ram_wraddress=000E, ram_data=0DB2, cpu_stall=0, host_gnt=0; no rvalid.
- CPU read after that store: cpu_req=1, cpu_we=0, cpu_addr=000E -> next cycle cpu_rvalid=1, cpu_rdata=0DB2; host_rvalid stays 0.
- Contention: cpu_req and host_req (read addr 0x0020) both held high, MAX_WAIT=4 -> host_gnt=0 for 4 cycles, host_gnt=1 with cpu_stall=1 on cycle 5, CPU granted again on cycle 6.
- Alternating reads: host reads 0x0010 (holding 0x1111) in cycle n, CPU reads 0x0011 (holding 0x2222) in cycle n+1 -> host_rvalid=1 with 1111 at n+1, cpu_rvalid=1 with 2222 at n+2, never overlapping.
- Reset mid-read: CPU read granted, then rst_n low before the next edge -> cpu_rvalid=0 and cpu_rdata=0 immediately, and remain 0 after release.
- Stats (macro defined): 6 contested cycles with MAX_WAIT=4 -> conflict_count=6, stall_count=1.
